// File: rtl/mul_share_ctrl_pkg.sv
// Shared definitions for the shared-multiplier controller.
//   - state_e: controller states (IDLE -> CALC -> RESP -> IDLE)
//   - clog2_min1: index width helper that never returns 0
package mul_share_ctrl_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // Width of an index/counter able to hold values 0..n-1, at least one bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mul_share_ctrl_if.sv
// Requester-side bus of the shared multiplier.
//   req_valid/req_ready : per-requester operation handshake (one-hot ready)
//   req_in1/req_in2     : packed operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid/rsp_ready : per-requester result handshake (one-hot valid)
//   rsp_out             : shared product bus, 2*WIDTH bits
//   busy                : controller not idle
// master = requester side, slave = controller side.
interface mul_share_ctrl_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_in1;
  logic [NREQ*WIDTH-1:0] req_in2;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ-1:0]       rsp_ready;
  logic [2*WIDTH-1:0]    rsp_out;
  logic                  busy;

  modport master (
    output req_valid, req_in1, req_in2, rsp_ready,
    input  req_ready, rsp_valid, rsp_out, busy
  );

  modport slave (
    input  req_valid, req_in1, req_in2, rsp_ready,
    output req_ready, rsp_valid, rsp_out, busy
  );
endinterface

// File: rtl/mul_share_ctrl_mult.sv
// Combinational unsigned multiplier array: p = a * b, exact 2*WIDTH product.
//   a, b : WIDTH-bit operands
//   p    : 2*WIDTH-bit product
module Multiplier #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] p
);
  assign p = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
endmodule

// File: rtl/mul_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req     : request vector
//   ptr     : index of last winner; scan starts at ptr+1 modulo N
//   gnt     : one-hot grant (all zero when no request)
//   gnt_idx : binary index of the grant (0 when no request)
module rr_arbiter
  import mul_share_ctrl_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]               req,
  input  logic [clog2_min1(N)-1:0]   ptr,
  output logic [N-1:0]               gnt,
  output logic [clog2_min1(N)-1:0]   gnt_idx
);
  localparam int IW = clog2_min1(N);

  logic          found_s;
  logic [IW-1:0] idx_s;

  // Scan ptr+1 .. ptr+N modulo N; first requester found wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found_s = 1'b0;
    idx_s   = '0;
    for (int k = 1; k <= N; k++) begin
      idx_s = IW'((int'(ptr) + k) % N);
      if (!found_s && req[idx_s]) begin
        found_s      = 1'b1;
        gnt[idx_s]   = 1'b1;
        gnt_idx      = idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end
endmodule

// File: rtl/mul_share_ctrl.sv
// Shares one combinational multiplier among NREQ requesters.
// Round-robin grant in IDLE, operands latched on accept, CALC_CYC settle
// cycles in CALC, result held in RESP until the granted requester accepts.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : requester bus (slave side), see mul_share_ctrl_if
module mul_share_ctrl
  import mul_share_ctrl_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int NREQ     = 4,
  parameter int CALC_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  mul_share_ctrl_if.slave   bus
);
  localparam int IW = clog2_min1(NREQ);
  localparam int CW = clog2_min1(CALC_CYC);

  state_e             state_q, state_d;
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]      gnt_q, gnt_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   op1_q, op1_d;
  logic [WIDTH-1:0]   op2_q, op2_d;
  logic [2*WIDTH-1:0] res_q, res_d;

  logic [NREQ-1:0]    arb_gnt_s;
  logic [IW-1:0]      arb_idx_s;
  logic [2*WIDTH-1:0] mult_p_s;
  logic [NREQ-1:0]    req_ready_s;
  logic [NREQ-1:0]    rsp_valid_s;
  logic [2*WIDTH-1:0] rsp_out_s;

  rr_arbiter #(.N(NREQ)) u_arb (
    .req     (bus.req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (arb_gnt_s),
    .gnt_idx (arb_idx_s)
  );

  // Multiplier sees only the latched operands, so its inputs are stable in CALC.
  Multiplier #(.WIDTH(WIDTH)) u_mult (
    .a (op1_q),
    .b (op2_q),
    .p (mult_p_s)
  );

  // Next-state and output decode.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_d       = gnt_q;
    cnt_d       = cnt_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    res_d       = res_q;
    req_ready_s = '0;
    rsp_valid_s = '0;
    rsp_out_s   = '0;
    case (state_q)
      S_IDLE: begin
        // Ready goes only to the winner, which is by construction valid,
        // so a nonzero grant is always a transfer.
        if (|arb_gnt_s) begin
          req_ready_s = arb_gnt_s;
          gnt_d       = arb_idx_s;
          cnt_d       = CW'(CALC_CYC - 1);
          state_d     = S_CALC;
          for (int i = 0; i < NREQ; i++) begin
            if (arb_gnt_s[i]) begin
              op1_d = bus.req_in1[i*WIDTH +: WIDTH];
              op2_d = bus.req_in2[i*WIDTH +: WIDTH];
            end else begin
              op1_d = op1_d;
              op2_d = op2_d;
            end
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        if (cnt_q == '0) begin
          res_d   = mult_p_s;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RESP: begin
        rsp_valid_s[gnt_q] = 1'b1;
        rsp_out_s          = res_q;
        // Only the granted requester's rsp_ready can complete the op.
        if (bus.rsp_ready[gnt_q]) begin
          rr_ptr_d = gnt_q;
          state_d  = S_IDLE;
        end else begin
          state_d  = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= IW'(NREQ - 1);
      gnt_q    <= '0;
      cnt_q    <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      cnt_q    <= cnt_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      res_q    <= res_d;
    end
  end

  assign bus.req_ready = req_ready_s;
  assign bus.rsp_valid = rsp_valid_s;
  assign bus.rsp_out   = rsp_out_s;
  assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mul_share_ctrl.sv
module tb_mul_share_ctrl;
  localparam int W  = 32;
  localparam int NR = 4;
  localparam int CC = 2;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  int          exp_idx_q[$];
  logic [63:0] exp_prod_q[$];

  mul_share_ctrl_if #(.NREQ(NR), .WIDTH(W)) bus ();

  mul_share_ctrl #(.WIDTH(W), .NREQ(NR), .CALC_CYC(CC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pop and compare whenever a response handshake completes.
  always @(negedge clk) begin
    if (!rst) begin
      if (|(bus.rsp_valid & bus.rsp_ready)) begin
        if (exp_idx_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got rsp_valid %b with empty scoreboard", bus.rsp_valid);
        end else begin
          int          ei;
          logic [63:0] ep;
          logic [3:0]  eoh;
          ei  = exp_idx_q.pop_front();
          ep  = exp_prod_q.pop_front();
          eoh = 4'b0001 << ei;
          check("rsp_valid_idx", {60'd0, bus.rsp_valid}, {60'd0, eoh});
          check("rsp_out", bus.rsp_out, ep);
        end
      end else begin
        if (bus.rsp_valid == 4'b0000 && bus.rsp_out !== 64'd0) begin
          checks++;
          errors++;
          $display("FAIL rsp_out_idle: got %0h expected 0", bus.rsp_out);
        end
      end
    end
  end

  task automatic wait_ready(output logic [3:0] r);
    r = 4'b0000;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (|bus.req_ready) begin
        r = bus.req_ready;
        break;
      end
    end
    if (r == 4'b0000) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got req_ready 0 expected a grant");
    end
  endtask

  // Present an operand for idx, check grant index, optionally score it, then drop valid.
  task automatic grant(input int idx, input logic [31:0] a, input logic [31:0] b, input bit push);
    logic [3:0] r;
    logic [3:0] eoh;
    bus.req_in1[idx*W +: W] = a;
    bus.req_in2[idx*W +: W] = b;
    bus.req_valid[idx]      = 1'b1;
    wait_ready(r);
    eoh = 4'b0001 << idx;
    check("req_ready_grant", {60'd0, r}, {60'd0, eoh});
    if (push) begin
      exp_idx_q.push_back(idx);
      exp_prod_q.push_back({32'd0, a} * {32'd0, b});
    end
    @(posedge clk);
    #1;
    bus.req_valid[idx] = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 60; n++) begin
      if (exp_idx_q.size() == 0) break;
      @(negedge clk);
    end
    if (exp_idx_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_idx_q.size());
      exp_idx_q.delete();
      exp_prod_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         lat;
    logic [3:0] r;
    logic [3:0] order [5];
    checks = 0;
    errors = 0;
    bus.req_valid = 4'b0000;
    bus.req_in1   = '0;
    bus.req_in2   = '0;
    bus.rsp_ready = 4'b1111;
    do_reset();

    // Reset state
    @(negedge clk);
    check("reset_busy", {63'd0, bus.busy}, 64'd0);
    check("reset_req_ready", {60'd0, bus.req_ready}, 64'd0);
    check("reset_rsp_valid", {60'd0, bus.rsp_valid}, 64'd0);
    check("reset_rsp_out", bus.rsp_out, 64'd0);
    @(posedge clk);
    #1;

    // 1: single op 7*6 with latency measurement
    grant(0, 32'd7, 32'd6, 1'b1);
    lat = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      lat++;
      if (|bus.rsp_valid) break;
    end
    check("latency", 64'(lat), 64'(CC + 1));
    drain();

    // 2: max operands
    grant(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    drain();
    check("max_prod_sanity", 64'hFFFF_FFFF * 64'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);

    // 3: all four continuously valid after reset -> 0,1,2,3,0
    do_reset();
    bus.req_in1 = {32'hFFFF_FFFF, 32'h0001_0000, 32'd100, 32'd3};
    bus.req_in2 = {32'd2,         32'h0001_0000, 32'd200, 32'd4};
    exp_prod_q.delete();
    order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_ready(r);
      check("rr_order", {60'd0, r}, {60'd0, order[k]});
      case (k % 4)
        0: begin exp_idx_q.push_back(0); exp_prod_q.push_back(64'd12); end
        1: begin exp_idx_q.push_back(1); exp_prod_q.push_back(64'd20000); end
        2: begin exp_idx_q.push_back(2); exp_prod_q.push_back(64'h1_0000_0000); end
        default: begin exp_idx_q.push_back(3); exp_prod_q.push_back(64'h1_FFFF_FFFE); end
      endcase
      @(posedge clk);
      #1;
      if (k == 4) bus.req_valid = 4'b0000;
    end
    drain();

    // 4: backpressure on req2, wrong-index rsp_ready, req1 waiting
    bus.rsp_ready = 4'b0000;
    grant(2, 32'd1234, 32'd5678, 1'b1);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (|bus.rsp_valid) break;
    end
    bus.rsp_ready = 4'b1011;
    bus.req_in1[1*W +: W] = 32'd11;
    bus.req_in2[1*W +: W] = 32'd13;
    bus.req_valid[1] = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check("bp_rsp_valid", {60'd0, bus.rsp_valid}, {60'd0, 4'b0100});
      check("bp_rsp_out", bus.rsp_out, 64'd7006652);
      check("bp_req_ready", {60'd0, bus.req_ready}, 64'd0);
      check("bp_busy", {63'd0, bus.busy}, 64'd1);
    end
    bus.rsp_ready = 4'b1111;
    grant(1, 32'd11, 32'd13, 1'b1);
    drain();

    // 5: reset during CALC discards the op
    grant(1, 32'd3, 32'd5, 1'b0);
    @(negedge clk);
    check("calc_busy", {63'd0, bus.busy}, 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_rsp_valid", {60'd0, bus.rsp_valid}, 64'd0);
    check("rst_rsp_out", bus.rsp_out, 64'd0);
    check("rst_req_ready", {60'd0, bus.req_ready}, 64'd0);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check("rst_no_rsp", {60'd0, bus.rsp_valid}, 64'd0);
    end
    @(posedge clk);
    #1;
    grant(1, 32'd2, 32'd9, 1'b1);
    drain();

    // 6: wrap 3 -> 0; just-served req3 loses to req0
    grant(3, 32'd9, 32'd9, 1'b1);
    drain();
    bus.req_in1[3*W +: W] = 32'd9;
    bus.req_in2[3*W +: W] = 32'd9;
    bus.req_valid[3] = 1'b1;
    grant(0, 32'd10, 32'd10, 1'b1);
    grant(3, 32'd9, 32'd9, 1'b1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
